// File: rtl/csr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csr_pkg : shared constants for the machine-mode CSR file                 |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH= 12'hB82;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [4:0] IRQ_CODE_MSI   = 5'd3;
    localparam logic [4:0] IRQ_CODE_MTI   = 5'd7;
    localparam logic [4:0] IRQ_CODE_MEI   = 5'd11;
    localparam int         IRQ_LOCAL_BASE = 16;

    localparam int          MSTATUS_MIE  = 3;
    localparam int          MSTATUS_MPIE = 7;
    localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;
    localparam logic [31:0] MISA_VALUE   = 32'h4000_0100;

    // Writable mie bits: the three standard sources plus the local lines.
    function automatic logic [31:0] mie_mask(input int num_local);
        logic [31:0] m;
        m = 32'h0000_0888;
        for (int i = 0; i < num_local; i++) begin
            m[IRQ_LOCAL_BASE + i] = 1'b1;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csr_counter64 : 64-bit counter with increment and per-half overwrite     |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // A write to either half takes the whole cycle; no increment alongside it.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0]  = wdata_i;
            if (wr_hi_i) cnt_d[63:32] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/csr_machine_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csr_machine_file : machine-mode CSRs, trap stacking, irq priority        |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module csr_machine_file
    import csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          NUM_LOCAL   = 16,
    parameter logic [31:0] MTVEC_RESET = 32'h8000_0004,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 csr_en_i,
    input  logic [1:0]           csr_op_i,
    input  logic                 csr_nowrite_i,
    input  logic [11:0]          csr_addr_i,
    input  logic [XLEN-1:0]      csr_wdata_i,
    output logic [XLEN-1:0]      csr_rdata_o,
    output logic                 csr_illegal_o,
    input  logic                 trap_entry_i,
    input  logic [XLEN-1:0]      trap_pc_i,
    input  logic [XLEN-1:0]      trap_tval_i,
    input  logic                 trap_intr_i,
    input  logic [4:0]           trap_code_i,
    input  logic                 mret_i,
    input  logic                 instret_inc_i,
    input  logic                 irq_soft_i,
    input  logic                 irq_timer_i,
    input  logic                 irq_ext_i,
    input  logic [NUM_LOCAL-1:0] irq_local_i,
    output logic                 irq_req_o,
    output logic [4:0]           irq_code_o,
    output logic [XLEN-1:0]      trap_target_o,
    output logic [XLEN-1:0]      mepc_out_o
);

    localparam logic [31:0] MIE_MASK = mie_mask(NUM_LOCAL);

    logic        st_mie_q,   st_mie_d;
    logic        st_mpie_q,  st_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mtval_q,    mtval_d;
    logic [31:0] mip_q,      mip_d;
    logic [63:0] mcycle, minstret;

    logic [31:0] rdata, wval, pending, tvec_base;
    logic        addr_unknown, addr_ro, write_attempt, csr_we;
    logic [4:0]  local_code;

    // ---------------- read mux ----------------
    always_comb begin
        rdata        = '0;
        addr_unknown = 1'b0;
        addr_ro      = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                rdata               = MSTATUS_MPP;
                rdata[MSTATUS_MIE]  = st_mie_q;
                rdata[MSTATUS_MPIE] = st_mpie_q;
            end
            CSR_MISA:      begin rdata = MISA_VALUE; addr_ro = 1'b1; end
            CSR_MIE:       rdata = mie_q;
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP:       begin rdata = mip_q; addr_ro = 1'b1; end
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRETH: rdata = minstret[63:32];
            CSR_MHARTID:   begin rdata = HART_ID; addr_ro = 1'b1; end
            default:       addr_unknown = 1'b1;
        endcase
    end

    assign write_attempt = csr_en_i && (csr_op_i != CSR_OP_NONE) && !csr_nowrite_i;
    assign csr_illegal_o = addr_unknown || (addr_ro && write_attempt);
    assign csr_we        = write_attempt && !csr_illegal_o && !trap_entry_i && !mret_i;
    assign csr_rdata_o   = rdata;

    always_comb begin
        case (csr_op_e'(csr_op_i))
            CSR_OP_RW: wval = csr_wdata_i;
            CSR_OP_RS: wval = rdata | csr_wdata_i;
            CSR_OP_RC: wval = rdata & ~csr_wdata_i;
            default:   wval = rdata;
        endcase
    end

    // ---------------- next state: trap > mret > csr write ----------------
    always_comb begin
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (trap_entry_i) begin
            mepc_d    = {trap_pc_i[31:2], 2'b00};
            mcause_d  = {trap_intr_i, 26'b0, trap_code_i};
            mtval_d   = trap_tval_i;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
        end else if (mret_i) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    st_mie_d  = wval[MSTATUS_MIE];
                    st_mpie_d = wval[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_d      = wval & MIE_MASK;
                CSR_MTVEC:    mtvec_d    = {wval[31:2], 1'b0, wval[0]};
                CSR_MSCRATCH: mscratch_d = wval;
                CSR_MEPC:     mepc_d     = {wval[31:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = wval;
                CSR_MTVAL:    mtval_d    = wval;
                default:      ;
            endcase
        end
    end

    always_comb begin
        mip_d               = '0;
        mip_d[IRQ_CODE_MSI] = irq_soft_i;
        mip_d[IRQ_CODE_MTI] = irq_timer_i;
        mip_d[IRQ_CODE_MEI] = irq_ext_i;
        for (int i = 0; i < NUM_LOCAL; i++) begin
            mip_d[IRQ_LOCAL_BASE + i] = irq_local_i[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
        end
    end

    // ---------------- counters ----------------
    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (1'b1),
        .wr_lo_i (csr_we && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi_i (csr_we && (csr_addr_i == CSR_MCYCLEH)),
        .wdata_i (wval),
        .count_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (instret_inc_i),
        .wr_lo_i (csr_we && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi_i (csr_we && (csr_addr_i == CSR_MINSTRETH)),
        .wdata_i (wval),
        .count_o (minstret)
    );

    // ---------------- interrupt request ----------------
    assign pending   = mip_q & mie_q;
    assign irq_req_o = st_mie_q && (pending != '0);

    // Descending scan so the lowest pending local index is the one kept.
    always_comb begin
        local_code = '0;
        for (int i = NUM_LOCAL - 1; i >= 0; i--) begin
            if (pending[IRQ_LOCAL_BASE + i]) local_code = 5'(IRQ_LOCAL_BASE + i);
        end
    end

    always_comb begin
        irq_code_o = '0;
        if (irq_req_o) begin
            if (pending[IRQ_CODE_MEI])      irq_code_o = IRQ_CODE_MEI;
            else if (pending[IRQ_CODE_MSI]) irq_code_o = IRQ_CODE_MSI;
            else if (pending[IRQ_CODE_MTI]) irq_code_o = IRQ_CODE_MTI;
            else                            irq_code_o = local_code;
        end
    end

    assign tvec_base     = {mtvec_q[31:2], 2'b00};
    assign trap_target_o = (mtvec_q[0] && trap_intr_i)
                         ? tvec_base + {25'b0, trap_code_i, 2'b00}
                         : tvec_base;
    assign mepc_out_o    = mepc_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_machine_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_csr_machine_file : directed stimulus with a cycle-level CSR model      |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module tb_csr_machine_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_en, csr_nowrite, csr_illegal;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        trap_entry, trap_intr, mret, instret_inc;
    logic [31:0] trap_pc, trap_tval, trap_target, mepc_out;
    logic [4:0]  trap_code, irq_code;
    logic        irq_soft, irq_timer, irq_ext, irq_req;
    logic [15:0] irq_local;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    csr_machine_file #(
        .XLEN        (32),
        .NUM_LOCAL   (16),
        .MTVEC_RESET (32'h8000_0004),
        .HART_ID     (32'h0000_0005)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .csr_en_i      (csr_en),
        .csr_op_i      (csr_op),
        .csr_nowrite_i (csr_nowrite),
        .csr_addr_i    (csr_addr),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_o   (csr_rdata),
        .csr_illegal_o (csr_illegal),
        .trap_entry_i  (trap_entry),
        .trap_pc_i     (trap_pc),
        .trap_tval_i   (trap_tval),
        .trap_intr_i   (trap_intr),
        .trap_code_i   (trap_code),
        .mret_i        (mret),
        .instret_inc_i (instret_inc),
        .irq_soft_i    (irq_soft),
        .irq_timer_i   (irq_timer),
        .irq_ext_i     (irq_ext),
        .irq_local_i   (irq_local),
        .irq_req_o     (irq_req),
        .irq_code_o    (irq_code),
        .trap_target_o (trap_target),
        .mepc_out_o    (mepc_out)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_mie, m_mpie;
    logic [31:0] m_mier, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
    logic [63:0] m_cyc, m_ins;
    logic [31:0] s_old, s_nv;
    logic        s_we;

    function automatic logic [31:0] m_rd(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h301: return 32'h4000_0100;
            12'h304: return m_mier;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'hB00: return m_cyc[31:0];
            12'hB02: return m_ins[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB82: return m_ins[63:32];
            12'hF14: return 32'h5;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_ill(input logic [11:0] a, input logic att);
        logic known, ro;
        known = (a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                           12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14});
        ro    = (a inside {12'h301, 12'h344, 12'hF14});
        return !known || (ro && att);
    endfunction

    // {req, code}: external, then software, then timer, then lowest local line.
    function automatic logic [5:0] m_irq();
        logic [31:0] p;
        p = m_mip & m_mier;
        if (!m_mie || p == 0) return 6'd0;
        if (p[11]) return {1'b1, 5'd11};
        if (p[3])  return {1'b1, 5'd3};
        if (p[7])  return {1'b1, 5'd7};
        for (int i = 16; i < 32; i++) if (p[i]) return {1'b1, 5'(i)};
        return 6'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_mier = 0; m_mtvec = 32'h8000_0004;
            m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0;
            m_cyc = 0; m_ins = 0;
        end else begin
            s_old = m_rd(csr_addr);
            s_we  = csr_en && csr_op != 2'b00 && !csr_nowrite &&
                    !m_ill(csr_addr, 1'b1) && !trap_entry && !mret;
            case (csr_op)
                2'b01:   s_nv = csr_wdata;
                2'b10:   s_nv = s_old | csr_wdata;
                2'b11:   s_nv = s_old & ~csr_wdata;
                default: s_nv = s_old;
            endcase
            if (trap_entry) begin
                m_mepc   = trap_pc & ~32'h3;
                m_mcause = {trap_intr, 26'b0, trap_code};
                m_mtval  = trap_tval;
                m_mpie   = m_mie;
                m_mie    = 0;
            end else if (mret) begin
                m_mie  = m_mpie;
                m_mpie = 1;
            end else if (s_we) begin
                case (csr_addr)
                    12'h300: begin m_mie = s_nv[3]; m_mpie = s_nv[7]; end
                    12'h304: m_mier     = s_nv & 32'hFFFF_0888;
                    12'h305: m_mtvec    = s_nv & ~32'h2;
                    12'h340: m_mscratch = s_nv;
                    12'h341: m_mepc     = s_nv & ~32'h3;
                    12'h342: m_mcause   = s_nv;
                    12'h343: m_mtval    = s_nv;
                    default: ;
                endcase
            end
            if (s_we && csr_addr == 12'hB00)      m_cyc[31:0]  = s_nv;
            else if (s_we && csr_addr == 12'hB80) m_cyc[63:32] = s_nv;
            else                                  m_cyc        = m_cyc + 1;
            if (s_we && csr_addr == 12'hB02)      m_ins[31:0]  = s_nv;
            else if (s_we && csr_addr == 12'hB82) m_ins[63:32] = s_nv;
            else if (instret_inc)                 m_ins        = m_ins + 1;
            m_mip = {irq_local, 4'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            logic [5:0]  ei;
            logic [31:0] tt;
            ei = m_irq();
            tt = (m_mtvec[0] && trap_intr) ? (m_mtvec & ~32'h3) + {25'b0, trap_code, 2'b00}
                                           : (m_mtvec & ~32'h3);
            check("cmp_rdata",   csr_rdata, m_rd(csr_addr));
            check("cmp_illegal", {31'b0, csr_illegal},
                  {31'b0, m_ill(csr_addr, csr_en && csr_op != 2'b00 && !csr_nowrite)});
            check("cmp_irq_req", {31'b0, irq_req}, {31'b0, ei[5]});
            check("cmp_irq_code", {27'b0, irq_code}, {27'b0, ei[4:0]});
            check("cmp_target",  trap_target, tt);
            check("cmp_mepc",    mepc_out, m_mepc);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle_inputs();
        csr_en = 0; csr_op = 0; csr_nowrite = 0; csr_addr = 0; csr_wdata = 0;
        trap_entry = 0; trap_intr = 0; trap_code = 0; trap_pc = 0; trap_tval = 0;
        mret = 0; instret_inc = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_en = 1; csr_op = op; csr_addr = a; csr_wdata = d;
        tick();
        idle_inputs();
    endtask

    task automatic check_rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
        csr_addr = a;
        @(negedge clk);
        check(nm, csr_rdata, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle_inputs();
        irq_soft = 0; irq_timer = 0; irq_ext = 0; irq_local = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_on = 1;

        check_rd(12'h300, 32'h0000_1800, "rst_mstatus");
        check_rd(12'h305, 32'h8000_0004, "rst_mtvec");
        check_rd(12'hF14, 32'h0000_0005, "rst_mhartid");
        check_rd(12'h341, 32'h0, "rst_mepc");
        csr_addr = 12'h7C0;
        @(negedge clk);
        check("unknown_rdata", csr_rdata, 32'h0);
        check("unknown_illegal", {31'b0, csr_illegal}, 32'h1);
        check("rst_irq_req", {31'b0, irq_req}, 32'h0);
        tick();

        csr_do(2'b10, 12'h300, 32'h8);
        check_rd(12'h300, 32'h0000_1808, "mstatus_rs");
        csr_do(2'b11, 12'h300, 32'h8);
        check_rd(12'h300, 32'h0000_1800, "mstatus_rc");
        csr_do(2'b01, 12'h300, 32'hFFFF_FFFF);
        check_rd(12'h300, 32'h0000_1888, "mstatus_rw_mask");

        csr_en = 1; csr_op = 2'b01; csr_addr = 12'hF14; csr_wdata = 32'h1;
        @(negedge clk);
        check("ro_write_illegal", {31'b0, csr_illegal}, 32'h1);
        tick();
        csr_op = 2'b10; csr_nowrite = 1;
        @(negedge clk);
        check("ro_nowrite_legal", {31'b0, csr_illegal}, 32'h0);
        tick();
        idle_inputs();
        check_rd(12'hF14, 32'h0000_0005, "ro_unchanged");

        csr_do(2'b01, 12'h304, 32'hFFFF_FFFF);
        check_rd(12'h304, 32'hFFFF_0888, "mie_mask");
        csr_do(2'b01, 12'h304, 32'h0000_0800);
        irq_ext = 1;
        @(negedge clk);
        check("irq_delay", {31'b0, irq_req}, 32'h0);
        tick();
        @(negedge clk);
        check("irq_ext_req", {31'b0, irq_req}, 32'h1);
        check("irq_ext_code", {27'b0, irq_code}, 32'd11);
        irq_timer = 1;
        csr_do(2'b01, 12'h304, 32'h0000_0880);
        @(negedge clk);
        check("irq_ext_over_timer", {27'b0, irq_code}, 32'd11);
        irq_ext = 0;
        tick();
        @(negedge clk);
        check("irq_timer_code", {27'b0, irq_code}, 32'd7);
        irq_local = 16'h0004;
        csr_do(2'b01, 12'h304, 32'h0004_0080);
        @(negedge clk);
        check("irq_timer_over_local", {27'b0, irq_code}, 32'd7);
        irq_timer = 0;
        tick();
        @(negedge clk);
        check("irq_local_code", {27'b0, irq_code}, 32'd18);
        csr_do(2'b11, 12'h300, 32'h8);
        @(negedge clk);
        check("irq_masked_req", {31'b0, irq_req}, 32'h0);
        check("irq_masked_code", {27'b0, irq_code}, 32'h0);
        irq_local = 0;
        csr_do(2'b10, 12'h300, 32'h8);

        csr_do(2'b01, 12'h305, 32'h0000_0103);
        check_rd(12'h305, 32'h0000_0101, "mtvec_bit1");
        trap_entry = 1; trap_intr = 1; trap_code = 5'd7; trap_pc = 32'h206; trap_tval = 32'h77;
        @(negedge clk);
        check("vectored_target", trap_target, 32'h0000_011C);
        tick();
        idle_inputs();
        csr_addr = 12'h342;
        @(negedge clk);
        check("trap_mcause", csr_rdata, 32'h8000_0007);
        check("trap_mepc_out", mepc_out, 32'h0000_0204);
        tick();
        check_rd(12'h300, 32'h0000_1880, "trap_mstatus");
        check_rd(12'h343, 32'h0000_0077, "trap_mtval");
        mret = 1;
        tick();
        idle_inputs();
        check_rd(12'h300, 32'h0000_1888, "mret_mstatus");
        trap_intr = 0; trap_code = 5'd3;
        @(negedge clk);
        check("exception_target", trap_target, 32'h0000_0100);
        tick();
        idle_inputs();

        csr_do(2'b01, 12'hB80, 32'h0000_0012);
        csr_do(2'b01, 12'hB00, 32'hFFFF_FFFF);
        check_rd(12'hB00, 32'hFFFF_FFFF, "mcycle_written");
        check_rd(12'hB80, 32'h0000_0013, "mcycleh_carry");
        check_rd(12'hB00, 32'h0000_0001, "mcycle_after_wrap");
        instret_inc = 1;
        csr_do(2'b01, 12'hB02, 32'h0000_0050);
        check_rd(12'hB02, 32'h0000_0050, "minstret_write_wins");
        instret_inc = 1;
        tick();
        idle_inputs();
        check_rd(12'hB02, 32'h0000_0051, "minstret_inc");

        csr_do(2'b01, 12'h340, 32'hAAAA_5555);
        trap_entry = 1; trap_intr = 0; trap_code = 5'd2; trap_pc = 32'h303; trap_tval = 32'hDEAD;
        csr_en = 1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1234_5678;
        tick();
        idle_inputs();
        check_rd(12'h340, 32'hAAAA_5555, "trap_drops_write");
        check_rd(12'h341, 32'h0000_0300, "trap2_mepc");
        check_rd(12'h342, 32'h0000_0002, "trap2_mcause");
        check_rd(12'h343, 32'h0000_DEAD, "trap2_mtval");
        check_rd(12'h300, 32'h0000_1880, "trap2_mstatus");
        mret = 1;
        csr_en = 1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1;
        tick();
        idle_inputs();
        check_rd(12'h340, 32'hAAAA_5555, "mret_drops_write");
        check_rd(12'h300, 32'h0000_1888, "mret2_mstatus");

        csr_en = 1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hFFFF;
        #2 rst = 1;
        #1 check("async_rst_mscratch", csr_rdata, 32'h0);
        idle_inputs();
        @(posedge clk);
        #1 rst = 0;
        check_rd(12'h300, 32'h0000_1800, "post_rst_mstatus");
        check_rd(12'h340, 32'h0, "post_rst_mscratch");

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
